// File: rtl/async_fifo_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : async_fifo_write_arbiter
//  Purpose  : Shares one async-FIFO write channel among NUM_REQ requesters in
//             the write clock domain. A round-robin arbiter grants the channel
//             to one requester at a time. The granted requester keeps the
//             channel for up to MAX_BURST beats, or until it flags its last
//             beat, or until it stops presenting valid. Each beat passes
//             through a one-entry output register that the FIFO full flag
//             holds back.
//  Ports    :
//    write_clk        in   write-domain clock
//    write_reset      in   asynchronous active-high reset
//    req_valid[N]     in   per-requester beat valid
//    req_data[N*W]    in   per-requester beat, requester i at [i*W +: W]
//    req_last[N]      in   per-requester last beat of the burst
//    req_ready[N]     out  beat accepted this cycle, if req_valid is also high
//    write_fifo_push  out  push strobe to the FIFO
//    write_data[W]    out  registered data to the FIFO
//    write_fifo_full  in   FIFO full flag
//    grant_id         out  current burst owner (meaningful while busy)
//    busy             out  a burst is in progress
//  Optional : When WRITE_ARB_STATS_EN is defined, these ports are added:
//    stat_beats[N*16]     per-requester saturating count of transferred beats
//    stat_full_stall[16]  saturating count of cycles the held beat was
//                         blocked by a full FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo_write_arbiter #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int NUM_REQ         = 4,
    parameter int MAX_BURST       = 8
) (
    input  logic                               write_clk,
    input  logic                               write_reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               write_fifo_push,
    output logic [FIFO_DATA_WIDTH-1:0]         write_data,
    input  logic                               write_fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
`ifdef WRITE_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]              stat_beats,
    output logic [15:0]                        stat_full_stall,
`endif
    output logic                               busy
);

    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                     state_q;
    logic [GRANT_W-1:0]         grant_q;
    logic [GRANT_W-1:0]         rr_ptr_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       out_valid_q;
    logic [FIFO_DATA_WIDTH-1:0] out_data_q;

    logic                       can_load;
    logic                       owner_valid;
    logic                       owner_last;
    logic [FIFO_DATA_WIDTH-1:0] owner_data;
    logic                       xfer;
    logic                       max_hit;
    logic                       burst_end;
    logic [GRANT_W-1:0]         winner;
    logic [GRANT_W:0]           idx_sum;
    logic [GRANT_W-1:0]         rr_ptr_d;
    logic [CNT_W-1:0]           cnt_d;

    // ------------------------------------------------------------------
    // Output stage: a beat drains whenever the FIFO is not full, and a new
    // beat may be loaded in the same cycle that the held one drains.
    // ------------------------------------------------------------------
    assign write_fifo_push = out_valid_q & ~write_fifo_full;
    assign can_load        = ~out_valid_q | write_fifo_push;
    assign write_data      = out_data_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q == ST_BURST);

    // Select the owner's request signals.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == ST_BURST) && (grant_q == GRANT_W'(i)) && can_load;
        end
    end

    // Round-robin pick. The loop scans from the farthest offset down to
    // offset 0, so the last match is the requester nearest to rr_ptr.
    always_comb begin
        winner  = rr_ptr_q;
        idx_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_sum = {1'b0, rr_ptr_q} + (GRANT_W+1)'(k);
            if (idx_sum >= (GRANT_W+1)'(NUM_REQ)) begin
                idx_sum = idx_sum - (GRANT_W+1)'(NUM_REQ);
            end
            if (req_valid[idx_sum[GRANT_W-1:0]]) begin
                winner = idx_sum[GRANT_W-1:0];
            end
        end
    end

    assign rr_ptr_d  = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign max_hit   = (cnt_d == CNT_W'(MAX_BURST));
    assign xfer      = (state_q == ST_BURST) & can_load & owner_valid;
    // The burst ends when the owner withdraws, or on a transfer that is its
    // last beat or that fills the beat budget. A stall on full is not an end.
    assign burst_end = (state_q == ST_BURST) & (~owner_valid | (xfer & (owner_last | max_hit)));

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (xfer) begin
                out_data_q  <= owner_data;
                out_valid_q <= 1'b1;
            end else if (write_fifo_push) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= winner;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (xfer) begin
                        cnt_q <= cnt_d;
                    end
                    if (burst_end) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WRITE_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_beats
            logic [15:0] beats_q;
            always_ff @(posedge write_clk or posedge write_reset) begin
                if (write_reset) begin
                    beats_q <= '0;
                end else if (xfer && (grant_q == GRANT_W'(gi)) && (beats_q != 16'hFFFF)) begin
                    beats_q <= beats_q + 16'd1;
                end
            end
            assign stat_beats[gi*16 +: 16] = beats_q;
        end
    endgenerate

    always_ff @(posedge write_clk or posedge write_reset) begin
        if (write_reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && write_fifo_full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
    assign stat_full_stall = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_write_arbiter
//  Purpose  : Scoreboard bench for async_fifo_write_arbiter. Each stimulus
//             phase loads per-requester beat queues. A transaction-level
//             round-robin/burst model predicts the order in which beats reach
//             the FIFO, and a monitor compares every push against that order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_write_arbiter;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int MB = 8;
    localparam int GW = 2;

    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    logic            write_clk       = 1'b0;
    logic            write_reset     = 1'b1;
    logic [NR-1:0]   req_valid       = '0;
    logic [NR-1:0]   req_last        = '0;
    logic [NR*W-1:0] req_data        = '0;
    logic            write_fifo_full = 1'b0;
    wire  [NR-1:0]   req_ready;
    wire             write_fifo_push;
    wire  [W-1:0]    write_data;
    wire  [GW-1:0]   grant_id;
    wire             busy;
`ifdef WRITE_ARB_STATS_EN
    wire  [NR*16-1:0] stat_beats;
    wire  [15:0]      stat_full_stall;
`endif

    async_fifo_write_arbiter #(
        .FIFO_DATA_WIDTH (W),
        .NUM_REQ         (NR),
        .MAX_BURST       (MB)
    ) dut (
        .write_clk       (write_clk),
        .write_reset     (write_reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .write_fifo_push (write_fifo_push),
        .write_data      (write_data),
        .write_fifo_full (write_fifo_full),
        .grant_id        (grant_id),
`ifdef WRITE_ARB_STATS_EN
        .stat_beats      (stat_beats),
        .stat_full_stall (stat_full_stall),
`endif
        .busy            (busy)
    );

    always #5 write_clk = ~write_clk;

    int        checks   = 0;
    int        failures = 0;
    beat_t     drvq  [NR][$];
    beat_t     stage [NR][$];
    logic [W-1:0] sb[$];
    int        rr_m      = 0;
    int        cyc       = 0;
    int        push_cnt  = 0;
    int        vstart    = -1;
    bit        log_en    = 1'b0;
    int        push_cyc[$];
    int        full_mode = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level reference: consumes the staged queues and appends
    // the expected FIFO beat order to the scoreboard.
    task automatic run_model();
        int w;
        int cnt;
        beat_t b;
        forever begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && stage[(rr_m + k) % NR].size() > 0) w = (rr_m + k) % NR;
            end
            if (w < 0) break;
            cnt = 0;
            forever begin
                b = stage[w].pop_front();
                sb.push_back(b.data);
                cnt++;
                if (b.last || cnt == MB || stage[w].size() == 0) break;
            end
            rr_m = (w + 1) % NR;
        end
    endtask

    task automatic load();
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < stage[i].size(); j++) drvq[i].push_back(stage[i][j]);
        end
        run_model();
    endtask

    function automatic bit drv_pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (drvq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge write_clk);
            #2;
        end
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while ((sb.size() != 0 || busy || drv_pending()) && n < maxc) begin
            @(negedge write_clk);
            #2;
            n++;
        end
        chk({"drain_", name}, W'(sb.size()), '0);
        if (n >= maxc) begin
            failures++;
            $display("FAIL timeout_%s actual=%0d required=<%0d", name, n, maxc);
        end
    endtask

    task automatic start_log();
        push_cyc.delete();
        vstart = -1;
        log_en = 1'b1;
    endtask

    // Sustained streaming: the k-th push lands 2 cycles after valid rises,
    // plus one bubble cycle per completed 8-beat grant.
    task automatic check_lat(input string name, input int n);
        log_en = 1'b0;
        chk({name, "_count"}, W'(push_cyc.size()), W'(n));
        for (int k = 0; k < push_cyc.size(); k++) begin
            chk(name, W'(push_cyc[k]), W'(vstart + 2 + k + k / MB));
        end
    endtask

    task automatic do_reset();
        write_reset = 1'b1;
        #1;
        chk("rst_push",  W'(write_fifo_push), '0);
        chk("rst_ready", W'(req_ready), '0);
        chk("rst_busy",  W'(busy), '0);
        chk("rst_data",  write_data, '0);
        chk("rst_grant", W'(grant_id), '0);
        for (int i = 0; i < NR; i++) drvq[i].delete();
        sb.delete();
        rr_m      = 0;
        full_mode = 0;
        wait_cycles(3);
        write_reset = 1'b0;
        wait_cycles(2);
    endtask

    // Monitor: compares every FIFO push against the scoreboard order.
    initial begin
        logic [NR-1:0] e;
        forever begin
            @(negedge write_clk);
            cyc++;
            if (log_en && vstart < 0 && |req_valid) vstart = cyc;
            if (write_fifo_push) begin
                push_cnt++;
                if (log_en) push_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_push actual=%h required=none", write_data);
                end else begin
                    chk("push_data", write_data, sb.pop_front());
                end
                chk("push_while_full", W'(write_fifo_full), '0);
            end
            if (req_ready != '0) begin
                e = '0;
                e[grant_id] = 1'b1;
                chk("ready_owner", W'(req_ready), W'(e));
                chk("ready_busy", W'(busy), 32'd1);
            end
        end
    end

    // Driver: presents the head of each requester queue and retires it on
    // a handshake.
    initial begin
        logic [NR-1:0]   acc;
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [NR*W-1:0] d;
        forever begin
            @(negedge write_clk);
            acc = req_valid & req_ready;
            @(posedge write_clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && drvq[i].size() > 0) drvq[i].delete(0);
            end
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < NR; i++) begin
                if (drvq[i].size() > 0) begin
                    v[i]         = 1'b1;
                    l[i]         = drvq[i][0].last;
                    d[i*W +: W]  = drvq[i][0].data;
                end
            end
            req_valid = v;
            req_last  = l;
            req_data  = d;
            case (full_mode)
                1:       write_fifo_full = ($urandom_range(0, 9) < 3);
                2:       write_fifo_full = 1'b1;
                default: write_fifo_full = 1'b0;
            endcase
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int cntb;
        wait_cycles(3);
        chk("reset_push",  W'(write_fifo_push), '0);
        chk("reset_ready", W'(req_ready), '0);
        chk("reset_busy",  W'(busy), '0);
        chk("reset_data",  write_data, '0);
        chk("reset_grant", W'(grant_id), '0);
        write_reset = 1'b0;
        wait_cycles(2);

        // Round-robin: all four continuously valid, no last flags.
        start_log();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 16; k++)
                stage[i].push_back(beat_t'{1'b0, {8'(i), 8'hB0, 16'(k)}});
        load();
        wait_drain("rr", 400);
        check_lat("rr_timing", 64);
        wait_cycles(2);

        // Single requester, 3 beats with last on the third.
        start_log();
        stage[0].push_back(beat_t'{1'b0, 32'h0000_00A0});
        stage[0].push_back(beat_t'{1'b0, 32'h0000_00A1});
        stage[0].push_back(beat_t'{1'b1, 32'h0000_00A2});
        load();
        wait_drain("single", 100);
        check_lat("single_timing", 3);
        chk("busy_after_last", W'(busy), '0);
        wait_cycles(2);

        // Full back-pressure mid-burst; pointer should now favour req1.
        stage[0].push_back(beat_t'{1'b0, 32'h0C00_0000});
        stage[0].push_back(beat_t'{1'b1, 32'h0C00_0001});
        for (int k = 0; k < 8; k++) stage[1].push_back(beat_t'{1'b0, 32'h0D00_0000 + 32'(k)});
        load();
        base = push_cnt;
        n    = 0;
        while (push_cnt - base < 3 && n < 100) begin
            wait_cycles(1);
            n++;
        end
        full_mode = 2;
        for (int s = 0; s < 5; s++) begin
            wait_cycles(1);
            chk("stall_push", W'(write_fifo_push), '0);
            chk("stall_data", write_data, (sb.size() > 0) ? sb[0] : 32'hDEAD_BEEF);
            chk("stall_ready", W'(req_ready[1]), '0);
            if (s == 4) full_mode = 0;
        end
        wait_drain("full", 200);
        wait_cycles(2);

        // Owner drop: req2 withdraws after 2 beats while req3 waits.
        stage[2].push_back(beat_t'{1'b0, 32'h0E00_0000});
        stage[2].push_back(beat_t'{1'b0, 32'h0E00_0001});
        for (int k = 0; k < 8; k++) stage[3].push_back(beat_t'{1'b0, 32'h0F00_0000 + 32'(k)});
        load();
        wait_drain("drop", 200);
        wait_cycles(2);

        // Random traffic with random back-pressure.
        full_mode = 1;
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < NR; i++) begin
                cntb = $urandom_range(0, 12);
                for (int k = 0; k < cntb; k++)
                    stage[i].push_back(beat_t'{($urandom_range(0, 3) == 0), {4'(i), 28'($urandom)}});
            end
            load();
            wait_drain("random", 2000);
        end
        full_mode = 0;
        wait_cycles(2);

        // Reset while a beat is held behind a full FIFO.
        full_mode = 2;
        wait_cycles(2);
        for (int k = 0; k < 4; k++) stage[0].push_back(beat_t'{1'b0, 32'h5A00_0010 + 32'(k)});
        load();
        wait_cycles(5);
        do_reset();

        // Arbitration restarts from requester 0.
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 2; k++)
                stage[i].push_back(beat_t'{1'b0, {8'(i), 8'h60, 16'(k)}});
        load();
        wait_drain("restart", 200);

`ifdef WRITE_ARB_STATS_EN
        wait_cycles(2);
        do_reset();
        for (int k = 0; k < 70000; k++) stage[1].push_back(beat_t'{1'b0, 32'(k)});
        load();
        wait_drain("stats", 100000);
        chk("stat_beats1", W'(stat_beats[16 +: 16]), 32'h0000_FFFF);
        chk("stat_beats0", W'(stat_beats[0 +: 16]), '0);
        chk("stat_beats2", W'(stat_beats[32 +: 16]), '0);
        chk("stat_beats3", W'(stat_beats[48 +: 16]), '0);
        chk("stat_stall",  W'(stat_full_stall), '0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
